warp_fetch_scheduler: RTL

- Upstream end of the dual-issue instruction-fetch interface.
- Holds the eight per-warp PCs and drives them to the fetch stage as PC0_PC_IF..PC7_PC_IF.
- Each cycle, chooses up to two distinct warps by round-robin and presents them as one-hot grants GRT_raw_1_RR_IF and GRT_raw_2_RR_IF.
- Advances granted PCs by 4. Applies branch/SIMT redirects and per-warp PC initialisation. Rate-limits each warp so it never has two fetches in flight.

---
 rtl/warp_fetch_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/warp_fetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : warp_fetch_scheduler
//  Description : Per-warp PC holder and dual-issue round-robin fetch arbiter.
//                Presents up to two distinct one-hot warp grants per cycle,
//                advances granted PCs by 4, applies redirects and PC
//                initialisation, and keeps each warp to one fetch in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module warp_fetch_scheduler #(
   parameter int          NUM_WARPS = 8,
   parameter int          FETCH_LAT = 3,
   parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_WARPS-1:0]         PC_Valid,
   input  logic [NUM_WARPS-1:0]         IBuf_Ready,
   input  logic                         Init_Wen,
   input  logic [$clog2(NUM_WARPS)-1:0] Init_WarpID,
   input  logic [31:0]                  Init_PC,
   input  logic                         Redirect_Valid,
   input  logic [$clog2(NUM_WARPS)-1:0] Redirect_WarpID,
   input  logic [31:0]                  Redirect_PC,
   output logic [31:0]                  PC0_PC_IF,
   output logic [31:0]                  PC1_PC_IF,
   output logic [31:0]                  PC2_PC_IF,
   output logic [31:0]                  PC3_PC_IF,
   output logic [31:0]                  PC4_PC_IF,
   output logic [31:0]                  PC5_PC_IF,
   output logic [31:0]                  PC6_PC_IF,
   output logic [31:0]                  PC7_PC_IF,
   output logic [NUM_WARPS-1:0]         GRT_raw_1_RR_IF,
   output logic [NUM_WARPS-1:0]         GRT_raw_2_RR_IF
);

   localparam int WID_W = $clog2(NUM_WARPS);
   localparam int CNT_W = $clog2(FETCH_LAT + 1);

   logic [31:0]          pc_q   [NUM_WARPS];
   logic [31:0]          pc_d   [NUM_WARPS];
   logic [CNT_W-1:0]     cnt_q  [NUM_WARPS];
   logic [CNT_W-1:0]     cnt_d  [NUM_WARPS];
   logic [NUM_WARPS-1:0] grt1_q, grt1_d;
   logic [NUM_WARPS-1:0] grt2_q, grt2_d;
   logic [WID_W-1:0]     ptr_q, ptr_d;
   // Held low for the first edge after reset so no grant is registered there.
   logic                 started_q;

   logic [NUM_WARPS-1:0] elig;
   logic [WID_W-1:0]     g1, g2, idx1, idx2;
   logic                 found1, found2;

   // Word alignment drops the two low PC bits of both write sources.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{Init_PC[1:0], Redirect_PC[1:0]};

   // A warp may be granted only when active, buffered, idle and not redirected.
   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         elig[w] = started_q && PC_Valid[w] && IBuf_Ready[w] &&
                   (cnt_q[w] == '0) && !grt1_q[w] && !grt2_q[w] &&
                   !(Redirect_Valid && (Redirect_WarpID == WID_W'(w)));
      end
   end

   // Round-robin pick of two distinct warps; index wrap relies on NUM_WARPS being a power of two.
   always_comb begin
      found1 = 1'b0;
      found2 = 1'b0;
      g1     = ptr_q;
      g2     = ptr_q;
      idx1   = '0;
      idx2   = '0;
      for (int k = 0; k < NUM_WARPS; k++) begin
         idx1 = ptr_q + WID_W'(k);
         if (!found1 && elig[idx1]) begin
            found1 = 1'b1;
            g1     = idx1;
         end
      end
      for (int k = 1; k < NUM_WARPS; k++) begin
         idx2 = g1 + WID_W'(k);
         if (found1 && !found2 && elig[idx2]) begin
            found2 = 1'b1;
            g2     = idx2;
         end
      end
      grt1_d = found1 ? (NUM_WARPS'(1) << g1) : '0;
      grt2_d = found2 ? (NUM_WARPS'(1) << g2) : '0;
      if (found2) begin
         ptr_d = g2 + WID_W'(1);
      end else if (found1) begin
         ptr_d = g1 + WID_W'(1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Per-warp PC and in-flight counter: redirect beats init beats grant advance.
   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         pc_d[w]  = pc_q[w];
         cnt_d[w] = (cnt_q[w] != '0) ? (cnt_q[w] - CNT_W'(1)) : '0;
         if (Redirect_Valid && (Redirect_WarpID == WID_W'(w))) begin
            pc_d[w]  = {Redirect_PC[31:2], 2'b00};
            cnt_d[w] = '0;
         end else if (Init_Wen && (Init_WarpID == WID_W'(w))) begin
            pc_d[w]  = {Init_PC[31:2], 2'b00};
            cnt_d[w] = '0;
         end else if (grt1_q[w] || grt2_q[w]) begin
            pc_d[w]  = pc_q[w] + 32'd4;
            cnt_d[w] = CNT_W'(FETCH_LAT - 1);
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            pc_q[w]  <= PC_RESET;
            cnt_q[w] <= '0;
         end
         grt1_q    <= '0;
         grt2_q    <= '0;
         ptr_q     <= '0;
         started_q <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            pc_q[w]  <= pc_d[w];
            cnt_q[w] <= cnt_d[w];
         end
         grt1_q    <= grt1_d;
         grt2_q    <= grt2_d;
         ptr_q     <= ptr_d;
         started_q <= 1'b1;
      end
   end

   assign GRT_raw_1_RR_IF = grt1_q;
   assign GRT_raw_2_RR_IF = grt2_q;
   assign PC0_PC_IF = pc_q[0];
   assign PC1_PC_IF = pc_q[1];
   assign PC2_PC_IF = pc_q[2];
   assign PC3_PC_IF = pc_q[3];
   assign PC4_PC_IF = pc_q[4];
   assign PC5_PC_IF = pc_q[5];
   assign PC6_PC_IF = pc_q[6];
   assign PC7_PC_IF = pc_q[7];

endmodule
`default_nettype wire
